// File: rtl/uart_rx_core.sv
// uart_rx_core: CE-gated UART receiver with optional parity, 1/2 stop bits and break recovery.
// Define UART_RX_OVERRUN_EN for a data-ready VALID level with RD_ACK/OVERRUN handshake.
module uart_rx_core #(
  parameter int CLK_PER_BIT = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 CE,
  input  logic                 DI,
`ifdef UART_RX_OVERRUN_EN
  input  logic                 RD_ACK,
  output logic                 OVERRUN,
`endif
  output logic [DATA_BITS-1:0] DATA_OUT,
  output logic                 VALID,
  output logic                 PARITY_ERR,
  output logic                 FRAME_ERR,
  output logic                 BUSY,
  output logic [2:0]           STATUS
);
  localparam int TICK_W = $clog2(CLK_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_READ   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  function automatic logic f_parity_err(input logic sample, input logic [DATA_BITS-1:0] data);
    logic x;
    x = sample ^ (^data);
    case (PARITY_MODE)
      1:       f_parity_err = x;
      2:       f_parity_err = ~x;
      default: f_parity_err = 1'b0;
    endcase
  endfunction

  state_t                r_state;
  logic                  r_sync1, r_sync2;
  logic [TICK_W-1:0]     r_tick;
  logic [BIT_W-1:0]      r_bit;
  logic [DATA_BITS-1:0]  r_shift;
  logic [DATA_BITS-1:0]  r_data;
  logic                  r_perr_lat, r_ferr_lat;
  logic                  r_valid, r_perr, r_ferr;
`ifdef UART_RX_OVERRUN_EN
  logic                  r_ovr;
`endif
  logic                  w_di, w_tick_last, w_done;

  // Two-flop synchroniser, free-running on CLK
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= DI;
      r_sync2 <= r_sync1;
    end
  end

  assign w_di        = r_sync2;
  assign w_tick_last = (r_tick == TICK_LAST);
  assign w_done      = CE && (r_state == S_STOP) && w_tick_last && (r_bit == STOP_LAST);

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state    <= S_IDLE;
      r_tick     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_perr_lat <= 1'b0;
      r_ferr_lat <= 1'b0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
`ifdef UART_RX_OVERRUN_EN
      r_ovr      <= 1'b0;
`endif
    end else begin
`ifdef UART_RX_OVERRUN_EN
      if (w_done) begin
        r_valid <= 1'b1;
        r_ovr   <= r_valid & ~RD_ACK;
      end else if (RD_ACK) begin
        r_valid <= 1'b0;
        r_ovr   <= 1'b0;
      end
`else
      r_valid <= w_done;
`endif
      // The final stop sample is folded in directly since the latch has not caught it yet
      if (w_done) begin
        r_data <= r_shift;
        r_perr <= r_perr_lat;
        r_ferr <= r_ferr_lat | ~w_di;
      end
      if (CE) begin
        case (r_state)
          S_IDLE: begin
            if (!w_di) begin
              r_state <= S_START;
              r_tick  <= '0;
            end
          end
          S_START: begin
            if (r_tick == TICK_MID) begin
              r_tick <= '0;
              if (w_di) begin
                r_state <= S_IDLE;
              end else begin
                r_state    <= S_READ;
                r_bit      <= '0;
                r_perr_lat <= 1'b0;
                r_ferr_lat <= 1'b0;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
          S_READ: begin
            if (w_tick_last) begin
              r_tick  <= '0;
              r_shift <= {w_di, r_shift[DATA_BITS-1:1]};
              if (r_bit == BIT_LAST) begin
                r_bit   <= '0;
                r_state <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
              end else begin
                r_bit <= r_bit + 1'b1;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
          S_PARITY: begin
            if (w_tick_last) begin
              r_tick     <= '0;
              r_perr_lat <= f_parity_err(w_di, r_shift);
              r_state    <= S_STOP;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
          S_STOP: begin
            if (w_tick_last) begin
              r_tick <= '0;
              if (r_bit == STOP_LAST) begin
                r_bit   <= '0;
                r_state <= (r_ferr_lat | ~w_di) ? S_BREAK : S_IDLE;
              end else begin
                r_bit <= r_bit + 1'b1;
                if (!w_di) r_ferr_lat <= 1'b1;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
          S_BREAK: begin
            if (w_di) r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
          end
        endcase
      end
    end
  end

  assign DATA_OUT   = r_data;
  assign VALID      = r_valid;
  assign PARITY_ERR = r_perr;
  assign FRAME_ERR  = r_ferr;
  assign BUSY       = (r_state != S_IDLE);
  assign STATUS     = r_state;
`ifdef UART_RX_OVERRUN_EN
  assign OVERRUN    = r_ovr;
`endif
endmodule
